// File: rtl/f1_light_seq.sv
// F1-style start light sequencer: lights fill one per en tick, hold for an
// LFSR-derived number of en ticks, then extinguish together with a go pulse.
module f1_light_seq #(
    parameter int         WIDTH  = 8,
    parameter int         HOLD_W = 7,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trigger,
    input  logic             mode,
    output logic [WIDTH-1:0] dout,
    output logic             go,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [7:0]        lfsr;
    logic              lfsr_fb;
    logic [WIDTH-1:0]  fill_next;
    logic [HOLD_W-1:0] hold_seed;

    // x^8+x^6+x^5+x^4+1 taps on bits 7,5,4,3
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign fill_next = {dout[WIDTH-2:0], 1'b1};
    assign hold_seed = lfsr[HOLD_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dout     <= '0;
            go       <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            lfsr     <= SEED;
        end else begin
            // LFSR free-runs so hold time depends on when the sequence began
            lfsr <= {lfsr[6:0], lfsr_fb};
            go   <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= FILL;
                        busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (en) begin
                        dout <= fill_next;
                        if (&fill_next) begin
                            state    <= HOLD;
                            hold_cnt <= (hold_seed == '0) ? HOLD_W'(1) : hold_seed;
                        end
                    end
                end
                HOLD: begin
                    if (en) begin
                        if (hold_cnt == HOLD_W'(1)) begin
                            dout     <= '0;
                            go       <= 1'b1;
                            hold_cnt <= '0;
                            state    <= mode ? FILL : IDLE;
                            busy     <= mode;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    dout  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_light_seq.sv
// Bench for f1_light_seq: directed steps plus random traffic, each cycle
// compared against a lit-count / hold-remaining reference model.
module tb_f1_light_seq;

    localparam int         WIDTH  = 8;
    localparam int         HOLD_W = 7;
    localparam logic [7:0] SEED   = 8'hA5;

    logic             clk = 1'b0;
    logic             rst, en, trigger, mode;
    logic [WIDTH-1:0] dout;
    logic             go, busy;

    int tests = 0;
    int fails = 0;

    // reference model: sequence active flag, number of lit lamps, en ticks
    // left before extinguish (0 while filling)
    bit         m_active = 1'b0;
    int         m_lit    = 0;
    int         m_hold   = 0;
    bit         m_go     = 1'b0;
    logic [7:0] m_lfsr   = SEED;
    int         m_hold_loaded = 0;
    bit         go_prev  = 1'b0;

    always #5 clk = ~clk;

    f1_light_seq #(.WIDTH(WIDTH), .HOLD_W(HOLD_W), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .mode(mode),
        .dout(dout), .go(go), .busy(busy)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [WIDTH-1:0] lamps(input int n);
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[i] = (i < n);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit t, input bit m);
        if (r) begin
            m_active = 0; m_lit = 0; m_hold = 0; m_go = 0; m_lfsr = SEED;
            return;
        end
        m_go = 0;
        if (!m_active) begin
            if (t) m_active = 1;
        end else if (m_hold == 0) begin
            if (e) begin
                m_lit++;
                if (m_lit == WIDTH) begin
                    m_hold = int'(m_lfsr) % (1 << HOLD_W);
                    if (m_hold == 0) m_hold = 1;
                    m_hold_loaded = m_hold;
                end
            end
        end else if (e) begin
            if (m_hold == 1) begin
                m_lit = 0; m_hold = 0; m_go = 1; m_active = m;
            end else begin
                m_hold--;
            end
        end
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic step(input bit r, input bit e, input bit t, input bit m);
        rst = r; en = e; trigger = t; mode = m;
        @(posedge clk);
        model(r, e, t, m);
        #1;
        chk("dout", 32'(dout), 32'(lamps(m_lit)));
        chk("go", 32'(go), 32'(m_go));
        chk("busy", 32'(busy), 32'(m_active));
        chk("thermometer", 32'(dout & (dout + 1'b1)), 32'd0);
        if (go_prev) chk("go_twice", 32'(go), 32'd0);
        go_prev = go;
    endtask

    initial begin
        int n;
        rst = 1; en = 0; trigger = 0; mode = 0;

        // reset from unknown state, then idle must stay quiet
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 1);

        // fill to 0x07, freeze with en low, stray trigger ignored
        step(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
        chk("fill_07", 32'(dout), 32'h07);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, (k == 4), 0);
            chk("freeze_07", 32'(dout), 32'h07);
        end
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
        chk("full_ff", 32'(dout), 32'hFF);

        // lamps stay lit for exactly the loaded hold count of en ticks
        n = 0;
        for (int k = 0; k < 400; k++) begin
            step(0, 1, 0, 0);
            n++;
            if (go) break;
        end
        chk("hold_len", 32'(n), 32'(m_hold_loaded));
        chk("go_pulse", 32'(go), 32'h1);
        chk("idle_after_go", 32'(busy), 32'h0);
        step(0, 0, 0, 0);
        chk("go_drop", 32'(go), 32'h0);

        // auto-repeat: consecutive fill, then refill straight after go
        step(0, 1, 1, 1);
        for (int k = 0; k < WIDTH; k++) begin
            step(0, 1, 0, 1);
            chk("fill_seq", 32'(dout), 32'(lamps(k + 1)));
        end
        for (int k = 0; k < 400 && !go; k++) step(0, 1, 0, 1);
        chk("go_first", 32'(go), 32'h1);
        chk("repeat_busy", 32'(busy), 32'h1);
        step(0, 1, 0, 1);
        chk("repeat_01", 32'(dout), 32'h01);
        for (int k = 0; k < 500 && !go; k++) step(0, 1, 0, 0);
        chk("go_second", 32'(go), 32'h1);
        chk("mode0_idle", 32'(busy), 32'h0);

        // reset while lamps are all lit
        step(0, 0, 1, 0);
        for (int k = 0; k < WIDTH; k++) step(0, 1, 0, 0);
        chk("pre_rst_ff", 32'(dout), 32'hFF);
        step(1, 1, 1, 1);
        chk("rst_hold_go", 32'(go), 32'h0);
        step(1, 1, 0, 1);
        step(0, 1, 0, 0);
        chk("rst_hold_idle", 32'(busy), 32'h0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        chk("restart_01", 32'(dout), 32'h01);

        // random traffic; mode wiggles freely to show it only matters at extinguish
        for (int k = 0; k < 4000; k++)
            step(($urandom % 300) == 0, ($urandom % 4) != 0,
                 ($urandom % 12) == 0, 1'($urandom % 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/f1_light_seq.md
F1_LIGHT_SEQ -- requirements
Module: f1_light_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of start lights (legal 2..16).
REQ-002 SHALL have parameter HOLD_W, default 7, width of random hold count (legal 1..8).
REQ-003 SHALL have parameter SEED, default 8'hA5, LFSR reset value (nonzero).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port en  input  1  step tick; sequence timing advances only on cycles with en=1.
REQ-007 SHALL have port trigger  input  1  start request, sampled every cycle regardless of en.
REQ-008 SHALL have port mode  input  1  0 = single sequence, 1 = auto-repeat.
REQ-009 SHALL have port dout  output  WIDTH  light pattern, bit 0 = first light.
REQ-010 SHALL have port go  output  1  one-cycle pulse when lights extinguish.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, FILL, HOLD; all outputs registered.
REQ-013 IDLE: dout=0, busy=0; trigger=1 SHALL move to FILL on next edge; en irrelevant.
REQ-014 FILL: each en=1 cycle SHALL update dout <= {dout[WIDTH-2:0],1'b1}; en=0 holds dout.
REQ-015 On the FILL en-cycle whose shift yields all ones, SHALL enter HOLD and load hold_cnt = lfsr[HOLD_W-1:0], substituting 1 if that value is 0.
REQ-016 HOLD: dout all ones; each en=1 cycle SHALL decrement hold_cnt; en=0 freezes it.
REQ-017 HOLD en-cycle with hold_cnt==1 SHALL clear dout to 0 and assert go for exactly that next cycle.
REQ-018 On that same edge, mode=0 SHALL enter IDLE; mode=1 SHALL enter FILL with dout=0.
REQ-019 All-ones pattern SHALL therefore be visible for exactly hold_cnt en-cycles.
REQ-020 LFSR SHALL be 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting left every clock cycle (independent of en and state), feedback into bit 0.
REQ-021 trigger while busy=1 SHALL be ignored; no restart, no queueing.
REQ-022 go SHALL never be high two consecutive cycles; go deasserts next cycle regardless of en.
REQ-023 mode SHALL be sampled only on the extinguish edge; changes elsewhere have no effect.
REQ-024 dout SHALL only contain contiguous ones from bit 0 (thermometer code) at all times.

Reset
REQ-025 rst=1 SHALL on the next edge force state IDLE, dout=0, go=0, busy=0, hold_cnt=0, lfsr=SEED.
REQ-026 rst SHALL take priority over trigger, en and every state transition, including mid-FILL and mid-HOLD.
REQ-027 After rst deasserts, no activity SHALL occur until trigger=1.

Verification
REQ-028 Reset: rst high 2 cycles from any state -> dout=0x00, go=0, busy=0 on the cycle after.
REQ-029 Fill, WIDTH=8: trigger pulse, en=1 every cycle -> dout 0x01,0x03,0x07,...,0xFF on 8 consecutive cycles, busy=1.
REQ-030 Freeze: en=0 for 10 cycles with dout=0x07 -> dout stays 0x07; trigger pulse in this window ignored.
REQ-031 Hold/go: hold_cnt loaded at FILL exit (checked against model LFSR from SEED, 0 -> 1) -> dout=0xFF for exactly hold_cnt en-cycles, then dout=0x00 with go=1 for one cycle, busy=0 (mode=0).
REQ-032 Auto-repeat: mode=1, en=1 -> after go, next en-cycle dout=0x01, busy stays 1, second go follows.
REQ-033 Reset mid-HOLD: rst asserted with dout=0xFF -> dout=0x00, no go pulse, IDLE; subsequent trigger restarts from 0x01.
